// File: rtl/video_lpf_ram_ctrl_pkg.sv
// Shared types and helpers for the recursive video low-pass filter frame controller.
package video_lpf_ctrl_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    PRIME    = 2'd1,
    RAMP     = 2'd2,
    RUN      = 2'd3
  } lpf_state_t;

  localparam int ALIGN_DELAY_DEFAULT = 4;

  // Full freeze (2^data_bits) is never issued, so the ceiling is one below it.
  function automatic int unsigned clamp_alpha(int unsigned a, int data_bits);
    int unsigned lim;
    lim = (32'd1 << data_bits) - 32'd1;
    return (a > lim) ? lim : a;
  endfunction

  function automatic int unsigned sat_add(int unsigned a, int unsigned b, int unsigned lim);
    int unsigned s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/video_lpf_ram_ctrl_if.sv
// Monitor tap on the filter core's input AXI4-Stream handshake.
interface video_lpf_ram_ctrl_if;
  logic mon_tuser0;
  logic mon_tvalid;
  logic mon_tready;

  modport master (output mon_tuser0, output mon_tvalid, output mon_tready);
  modport slave  (input  mon_tuser0, input  mon_tvalid, input  mon_tready);
endinterface

// File: rtl/video_lpf_alpha_delay.sv
// Enable-gated shift line with asynchronous clear; aligns alpha to the core multiply stage.
module video_lpf_alpha_delay #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_p [DEPTH];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
    end else if (en) begin
      stage_p[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign q = stage_p[DEPTH-1];

endmodule

// File: rtl/video_lpf_ram_ctrl.sv
// Frame-level alpha controller: primes the frame RAM, ramps alpha per frame and
// checks frame length, with alpha changes delay-aligned to the first pixel of a frame.
module video_lpf_ram_ctrl
  import video_lpf_ctrl_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int ADDR_BITS   = 17,
  parameter int MEM_SIZE    = 1 << ADDR_BITS,
  parameter int ALIGN_DELAY = ALIGN_DELAY_DEFAULT,
  parameter int CNT_BITS    = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  video_lpf_ram_ctrl_if.slave   mon,
  input  logic                  enable,
  input  logic [DATA_BITS:0]    target_alpha,
  input  logic [DATA_BITS:0]    ramp_step,
  input  logic                  err_clear,
  output logic [DATA_BITS:0]    param_alpha,
  output logic [1:0]            stat_state,
  output logic [DATA_BITS:0]    stat_alpha,
  output logic [CNT_BITS-1:0]   stat_frames,
  output logic                  err_size,
  output logic                  err_over
);

  localparam int AW = DATA_BITS + 1;
  localparam int CW = ADDR_BITS + 1;
  localparam logic [CW-1:0] MEM_CNT = CW'(MEM_SIZE);
  localparam logic [CW-1:0] MAX_CNT = CW'(MEM_SIZE + 1);

  lpf_state_t     state, state_nx;
  logic [AW-1:0]  alpha, alpha_nx, tgt, base, a_step, dly_in;
  logic [CW-1:0]  beat_cnt, ref_len;
  logic           accept, sof, chk, over, size_bad, err_now;

  assign accept = mon.mon_tvalid & mon.mon_tready;
  assign sof    = accept & mon.mon_tuser0;

  always_comb begin
    tgt      = AW'(clamp_alpha(32'(target_alpha), DATA_BITS));
    base     = (state == PRIME) ? '0 : alpha;
    a_step   = (ramp_step == '0) ? tgt : AW'(sat_add(32'(base), 32'(ramp_step), 32'(tgt)));
    // The frame that defines the reference length is not held against the old one.
    chk      = (state != DISABLED);
    over     = chk && (beat_cnt > MEM_CNT);
    size_bad = chk && (state != PRIME) && (beat_cnt != ref_len);
    err_now  = over | size_bad;
    state_nx = state;
    alpha_nx = alpha;
    if (!enable) begin
      state_nx = DISABLED;
      alpha_nx = '0;
    end else if (err_now || state == DISABLED) begin
      state_nx = PRIME;
      alpha_nx = '0;
    end else begin
      alpha_nx = a_step;
      state_nx = (a_step == tgt) ? RUN : RAMP;
    end
    dly_in = sof ? alpha_nx : alpha;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= DISABLED;
      alpha       <= '0;
      beat_cnt    <= '0;
      ref_len     <= '0;
      stat_frames <= '0;
      err_size    <= 1'b0;
      err_over    <= 1'b0;
    end else begin
      if (accept) begin
        if (sof)                   beat_cnt <= CW'(1);
        else if (beat_cnt != MAX_CNT) beat_cnt <= beat_cnt + CW'(1);
      end
      if (sof) begin
        state       <= state_nx;
        alpha       <= alpha_nx;
        stat_frames <= stat_frames + CNT_BITS'(1);
        if (state == PRIME) ref_len <= beat_cnt;
      end
      if (sof && over)        err_over <= 1'b1;
      else if (err_clear)     err_over <= 1'b0;
      if (sof && size_bad)    err_size <= 1'b1;
      else if (err_clear)     err_size <= 1'b0;
    end
  end

  // Alignment stages: shift with the core pipeline, tail drives the core.
  video_lpf_alpha_delay #(
    .WIDTH (AW),
    .DEPTH (ALIGN_DELAY)
  ) u_alpha_delay (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (mon.mon_tready),
    .d       (dly_in),
    .q       (param_alpha)
  );

  assign stat_state = state;
  assign stat_alpha = alpha;

endmodule
